// File: rtl/pong_pkg.sv
// Screen geometry, link-lost message code and the packed formats of the two
// state words the game CPU writes into the frame controller.
package pong_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int PADDLEHEIGHT = 50;

    localparam logic [2:0] MSG_LINK_LOST = 3'd7;

    localparam logic [9:0] BALLX_MAX  = 10'(SCREEN_W - 1);
    localparam logic [9:0] BALLY_MAX  = 10'(SCREEN_H - 1);
    localparam logic [9:0] PADDLE_MAX = 10'(SCREEN_H - PADDLEHEIGHT);

    typedef struct packed {
        logic [9:0] ballx;
        logic [9:0] bally;
        logic [5:0] score1;
        logic [5:0] score2;
    } word_a_t;

    typedef struct packed {
        logic [9:0] paddle1;
        logic [9:0] paddle2;
        logic [8:0] sound_sel;
        logic [2:0] msg_sel;
    } word_b_t;

    // Ball centred, paddles centred, everything else blank.
    localparam word_a_t WORD_A_RST = '{ballx: 10'd320, bally: 10'd240,
                                       score1: 6'd0, score2: 6'd0};
    localparam word_b_t WORD_B_RST = '{paddle1: 10'd215, paddle2: 10'd215,
                                       sound_sel: 9'd0, msg_sel: 3'd0};

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_COMMIT = 2'd1,
        ST_BLANK  = 2'd2
    } fsm_state_t;

    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/frame_state_ctrl_if.sv
// Write port from the game CPU: two independent one-cycle word strobes.
interface frame_state_ctrl_if;

    logic        word_a_valid;
    logic [31:0] word_a;
    logic        word_b_valid;
    logic [31:0] word_b;

    modport master (
        output word_a_valid,
        output word_a,
        output word_b_valid,
        output word_b
    );

    modport slave (
        input word_a_valid,
        input word_a,
        input word_b_valid,
        input word_b
    );

endinterface

// File: rtl/frame_state_ctrl_unpack.sv
// Splits a state word and clamps its two leading 10-bit coordinate fields;
// the low 12 bits pass through untouched. Both word formats share this layout.
module state_word_unpack
    import pong_pkg::*;
#(
    parameter logic [9:0] HI_MAX  = BALLX_MAX,
    parameter logic [9:0] MID_MAX = BALLY_MAX
) (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    logic [9:0]  hi_fld;
    logic [9:0]  mid_fld;
    logic [11:0] lo_fld;

    assign hi_fld  = word_i[31:22];
    assign mid_fld = word_i[21:12];
    assign lo_fld  = word_i[11:0];

    assign word_o = {clamp10(hi_fld, HI_MAX), clamp10(mid_fld, MID_MAX), lo_fld};

endmodule

// File: rtl/frame_state_ctrl.sv
// Frame-synchronous publication of CPU-written display state: words are
// shadowed at any time and copied to the outputs once per vsync falling edge.
module frame_state_ctrl
    import pong_pkg::*;
#(
    parameter int STALE_FRAMES = 30,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                vgaclk,
    input  logic                reset,
    input  logic                vsync,
    frame_state_ctrl_if.slave   wr,
    input  logic                frame_cnt_ld,
    input  logic [15:0]         frame_cnt_ld_val,
    output logic [9:0]          ballx,
    output logic [9:0]          bally,
    output logic [9:0]          paddle1,
    output logic [9:0]          paddle2,
    output logic [5:0]          score1,
    output logic [5:0]          score2,
    output logic [8:0]          sound_sel,
    output logic [2:0]          msg_sel,
    output logic                commit,
    output logic                stale,
    output logic                blink,
    output logic [15:0]         frame_cnt
);

    localparam int MISS_W  = $clog2(STALE_FRAMES + 1);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(STALE_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_END = BLINK_W'(BLINK_FRAMES - 1);

    fsm_state_t          state_q, state_d;
    logic                vsync_q;
    logic                vsync_fall;
    logic                in_commit;

    logic [31:0]         shad_a_q, shad_a_d;
    logic [31:0]         shad_b_q, shad_b_d;
    logic                pend_a_q, pend_a_d;
    logic                pend_b_q, pend_b_d;
    logic [31:0]         clamp_a, clamp_b;
    word_a_t             out_a_q, out_a_d;
    word_b_t             out_b_q, out_b_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_q, blink_d;

    assign vsync_fall = vsync_q & ~vsync;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) state_q <= ST_ACTIVE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // BLANK only leaves on vsync high, so a repeated fall inside the
    // sync pulse cannot trigger a second commit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ACTIVE: if (vsync_fall) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_BLANK;
            ST_BLANK:  if (vsync) state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_commit = (state_q == ST_COMMIT);
        commit    = in_commit & (pend_a_q | pend_b_q);
    end

    state_word_unpack #(.HI_MAX(BALLX_MAX), .MID_MAX(BALLY_MAX)) u_unpack_a (
        .word_i (shad_a_q),
        .word_o (clamp_a)
    );

    state_word_unpack #(.HI_MAX(PADDLE_MAX), .MID_MAX(PADDLE_MAX)) u_unpack_b (
        .word_i (shad_b_q),
        .word_o (clamp_b)
    );

    // ---------------- datapath next state ----------------
    always_comb begin
        shad_a_d    = shad_a_q;
        shad_b_d    = shad_b_q;
        pend_a_d    = pend_a_q;
        pend_b_d    = pend_b_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        miss_d      = miss_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;

        // Publish uses the shadow as it stood entering COMMIT; a strobe in
        // the same cycle refills the shadow and keeps pend for next frame.
        if (in_commit && pend_a_q) out_a_d = word_a_t'(clamp_a);
        if (in_commit && pend_b_q) out_b_d = word_b_t'(clamp_b);

        if (wr.word_a_valid) begin
            shad_a_d = wr.word_a;
            pend_a_d = 1'b1;
        end else if (in_commit) begin
            pend_a_d = 1'b0;
        end

        if (wr.word_b_valid) begin
            shad_b_d = wr.word_b;
            pend_b_d = 1'b1;
        end else if (in_commit) begin
            pend_b_d = 1'b0;
        end

        if (in_commit) begin
            if (commit)                miss_d = '0;
            else if (miss_q != MISS_MAX) miss_d = miss_q + 1'b1;

            frame_cnt_d = frame_cnt_q + 16'd1;

            if (blink_cnt_q == BLINK_END) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (frame_cnt_ld) frame_cnt_d = frame_cnt_ld_val;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            vsync_q     <= 1'b1;
            shad_a_q    <= '0;
            shad_b_q    <= '0;
            pend_a_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            out_a_q     <= WORD_A_RST;
            out_b_q     <= WORD_B_RST;
            miss_q      <= '0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            shad_a_q    <= shad_a_d;
            shad_b_q    <= shad_b_d;
            pend_a_q    <= pend_a_d;
            pend_b_q    <= pend_b_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            miss_q      <= miss_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign ballx     = out_a_q.ballx;
    assign bally     = out_a_q.bally;
    assign score1    = out_a_q.score1;
    assign score2    = out_a_q.score2;
    assign paddle1   = out_b_q.paddle1;
    assign paddle2   = out_b_q.paddle2;
    assign sound_sel = out_b_q.sound_sel;

    // Link-lost overrides the message without touching the committed value.
    assign stale     = (miss_q >= MISS_MAX);
    assign msg_sel   = stale ? MSG_LINK_LOST : out_b_q.msg_sel;
    assign blink     = blink_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/frame_state_ctrl.md
FRAME_STATE_CTRL -- requirements
Module: frame_state_ctrl

Interface
REQ-001 Parameter STALE_FRAMES, default 30: consecutive frames without a commit before the link is flagged stale.
REQ-002 Parameter BLINK_FRAMES, default 16: frames per blink half-period.
REQ-003 vgaclk  in  1  pixel clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 vsync  in  1  active-low vertical sync from the VGA controller, synchronous to vgaclk.
REQ-006 word_a_valid  in  1  one-cycle strobe; word_a holds a new ball/score word.
REQ-007 word_a  in  32  {ballx[9:0], bally[9:0], score1[5:0], score2[5:0]}.
REQ-008 word_b_valid  in  1  one-cycle strobe; word_b holds a new paddle/sound/message word.
REQ-009 word_b  in  32  {paddle1[9:0], paddle2[9:0], sound_sel[8:0], msg_sel[2:0]}.
REQ-010 ballx, bally, paddle1, paddle2  out  10 each  committed display state.
REQ-011 score1, score2  out  6 each; sound_sel  out  9; msg_sel  out  3.
REQ-012 commit  out  1  one-cycle pulse on any frame commit.
REQ-013 stale  out  1  link-lost flag.
REQ-014 blink  out  1  frame-rate square wave for message flashing.
REQ-015 frame_cnt  out  16  frames since reset.

Function
REQ-016 The block SHALL register vsync and detect the frame boundary as vsync_q=1 & vsync=0 (the falling edge).
REQ-017 The FSM SHALL have three states: ACTIVE, COMMIT and BLANK.
REQ-018 The FSM SHALL move ACTIVE->COMMIT on the frame boundary, COMMIT->BLANK unconditionally after 1 cycle, and BLANK->ACTIVE when vsync=1.
REQ-019 On word_x_valid in any state, the block SHALL load the word into shadow register x and set pend_x; the last strobe before commit wins.
REQ-020 In COMMIT, each pending word SHALL be copied to its outputs and its pend flag cleared, independently for A and B.
REQ-021 commit SHALL pulse in COMMIT iff at least one word was pending; outputs SHALL be updated in the cycle after COMMIT and never otherwise.
REQ-022 A strobe coinciding with the COMMIT cycle SHALL commit the previous shadow value, load the new word into the shadow, and leave pend set so it commits at the next frame.
REQ-023 On commit, ballx SHALL clamp to 639, bally to 479, and paddle1/paddle2 to 430; all other fields SHALL pass unmodified.
REQ-024 A missed-frame counter SHALL increment (saturating at STALE_FRAMES) at each COMMIT with nothing pending, and clear to 0 on any commit.
REQ-025 stale SHALL equal (missed counter >= STALE_FRAMES).
REQ-026 While stale=1, msg_sel SHALL output 3'd7 regardless of the committed value; the committed value SHALL reappear once stale clears.
REQ-027 frame_cnt SHALL increment at each COMMIT state, wrapping from 65535 to 0.
REQ-028 blink SHALL toggle every BLINK_FRAMES COMMIT states, using its own counter.
REQ-029 A second vsync falling edge without an intervening vsync=1 SHALL be ignored (BLANK holds).

Reset
REQ-030 Reset SHALL force state to ACTIVE, pend flags to 0, shadows to 0, and vsync_q to 1.
REQ-031 Reset SHALL set ballx=320, bally=240, paddle1=paddle2=215, scores=0, sound_sel=0, msg_sel=0.
REQ-032 Reset SHALL clear commit, stale, blink, frame_cnt and all counters to 0.
REQ-033 Reset asserted mid-frame SHALL discard pending words, and the first commit after reset SHALL require a fresh strobe.

Structure
REQ-034 The screen constants (640, 480, PADDLEHEIGHT 50, MSG_LINK_LOST 3'd7) and the packed struct types for word A and word B SHALL live in shared package pong_pkg.
REQ-035 Unpacking and clamping SHALL be one combinational sub-module, state_word_unpack, instantiated once per word type.

Verification
REQ-036 Strobe word_a with ballx=700, bally=100, then a vsync fall -> one commit pulse; ballx=639, bally=100; paddles unchanged at 215.
REQ-037 Strobe word_b twice in one frame (paddle1=100, then 200) -> after the vsync fall, paddle1=200 and exactly one commit pulse.
REQ-038 Strobe word_a in the COMMIT cycle with a prior pending value X, new value Y -> X committed this frame, Y committed next frame.
REQ-039 30 frames with no strobes -> stale=1 and msg_sel=7 after the 30th fall; one word_b with msg_sel=2 -> stale=0 and msg_sel=2 after the next fall.
REQ-040 Run 32 frames -> blink toggles at frames 16 and 32, and frame_cnt=32; preload to 65535, one frame -> frame_cnt=0.
REQ-041 Assert reset with pend_a set -> outputs at reset values; the next vsync fall with no strobe -> no commit pulse.
